histogram_haritalama: RTL and testbench
=======================================

# histogram_haritalama

Parametrised, fully pipelined histogram-equalisation mapper. It converts a pixel's CDF value into an equalised output level, `round((cdf - cdf_min) * L / (M*N - cdf_min))` with `L = 2^PIKSEL_W - 1`, at one pixel per cycle. It generalises the fixed 8-bit mapper with:

- configurable pixel depth and image size,
- a per-beat channel tag carried through the pipeline,
- a bypass mode,
- defined degenerate-histogram and out-of-range handling.

It sits between the CDF lookup RAM and the output pixel stream.

## Interface
- `M`, default 320: image width in pixels.
- `N`, default 240: image height in pixels.
- `PIKSEL_W`, default 8: pixel bit width; `L = 2^PIKSEL_W - 1`.
- `KANAL_W`, default 2: width of the channel tag.
- `CDF_W` (localparam): `$clog2(M*N+1)`, which is 17 for the defaults.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rstn_i`  in  1  reset; synchronous, active-low.
- `etkin_i`  in  1  input beat valid.
- `stal_i`  in  1  global stall; freezes the entire pipeline.
- `mod_i`  in  1  0 = equalise, 1 = bypass (output = `piksel_i`).
- `piksel_i`  in  PIKSEL_W  original pixel value; used in bypass and degenerate cases.
- `kanal_i`  in  KANAL_W  channel tag, returned unchanged on `kanal_o`.
- `cdf_min_i`  in  CDF_W  smallest non-zero CDF of the histogram.
- `cdf_i`  in  CDF_W  CDF value at `piksel_i`.
- `sonuc_o`  out  PIKSEL_W  mapped pixel (registered).
- `kanal_o`  out  KANAL_W  tag of the beat on `sonuc_o` (registered).
- `hazir_o`  out  1  output beat valid (registered).
- `mesgul_o`  out  1  OR of all pipeline valid bits, including the output stage.

## Operation
- **Input acceptance.** A beat is accepted on a rising edge where `etkin_i=1` and `stal_i=0`. `etkin_i` is ignored while `stal_i=1`.
- **Stage S0 (subtract/classify).** Registers the following:
  - `num = cdf_i - cdf_min_i`, width CDF_W+1.
  - `den = M*N - cdf_min_i`, width CDF_W+1.
  - Tag, pixel, mode, and a class code. Class codes are evaluated in this priority order:
    1. BYPASS if `mod_i=1`.
    2. ZERO if `cdf_i < cdf_min_i` (num sign bit set).
    3. IDENT if `den == 0` (single-valued image).
    4. SAT if `cdf_i > M*N`.
    5. NORM otherwise.
- **Stage S1 (dividend/divisor).**
  - Dividend `D = 2*num*L + den`, width CDF_W+PIKSEL_W+2. Compute `num*L` as `(num<<PIKSEL_W) - num`; no multiplier.
  - Divisor `2*den`.
- **Stages S2..S(PIKSEL_W+1) (division).** PIKSEL_W restoring-divide stages, one quotient bit per stage, MSB first.
  - Stage k compares the partial remainder against `(2*den) << (PIKSEL_W-1-k)`.
  - If remainder ≥ shifted divisor: subtract and shift in 1; otherwise shift in 0.
  - Tag, pixel and class travel alongside.
- **Quotient range.** The quotient is `floor(D / (2*den))`, which is round-half-up of the exact ratio. Because `num ≤ den` for NORM, the quotient is ≤ L and no overflow bit is needed.
- **Output stage.** `sonuc_o` is selected by class:
  - BYPASS → `piksel`
  - ZERO → 0
  - IDENT → `piksel`
  - SAT → L
  - NORM → quotient
  
  `kanal_o` is the carried tag. `hazir_o` is the carried valid bit.
- **Independence of class.** Every beat, of any class, takes the same latency; classes never reorder beats. Divider contents for non-NORM beats are don't-care.
- **Operand source.** Only registered S0 values feed later stages. Inputs may change every cycle.

## Timing
- **Latency.** `LAT = PIKSEL_W + 3` unstalled cycles (11 for defaults). A beat accepted at edge t appears with `hazir_o=1` after edge t+LAT-1, i.e. it is visible during cycle t+LAT.
- **Throughput.** One beat per cycle. Back-to-back beats produce back-to-back `hazir_o`.
- **Stall.**
  - While `stal_i=1` every pipeline register, including `sonuc_o`, `kanal_o` and `hazir_o`, holds its value.
  - Downstream consumes a beat only on a cycle with `hazir_o=1` and `stal_i=0`.
  - Stalling adds exactly one cycle of latency per stalled cycle.
  - No beat is lost or duplicated.
- **Reset.** A rising edge with `rstn_i=0` clears every valid bit and data register. In the following cycle `sonuc_o=0`, `kanal_o=0`, `hazir_o=0`, `mesgul_o=0`. Reset has priority over `stal_i`.
- **Reset mid-operation.** All in-flight beats are discarded. The first beat accepted after release has normal latency.
- **Simultaneous events.** `etkin_i=1` with `stal_i=1` is not accepted; the source must hold it.
- **`mesgul_o`.** Falls in the cycle after the last beat leaves the output stage.

## Test plan
- **Full range.** Defaults, `mod_i=0`, `cdf_min=0`, `cdf=76800` → `sonuc_o=255` after 11 cycles. `cdf=38400` → 128 (127.5 rounds up). `cdf=0` → 0.
- **Ordering and tags.** `cdf_min=100`, streaming `cdf` = 50, 100, 76800, 38450 on consecutive cycles with tags 0, 1, 2, 3 → outputs 0, 0, 255, 128 on consecutive cycles, same tag order, `hazir_o` high for 4 cycles.
- **Degenerate / out-of-range classes.**
  - Degenerate: `cdf_min=cdf=76800`, `piksel=0x3C` → `0x3C`.
  - Bypass: `mod_i=1`, `piksel=0x5A`, any CDF → `0x5A`.
  - Saturation: `cdf=76801`, `cdf_min=0` → 255.
- **Stall.** Stream 20 random beats with `stal_i` pulsed for 1, 3 and 7 cycles mid-stream. Every output must match a reference model `floor((2*num*255 + den) / (2*den))`, in order, with none lost or duplicated. Outputs must hold during stall.
- **Reset mid-operation.** Assert `rstn_i=0` for 1 cycle with 5 beats in flight → no `hazir_o` afterwards. A new beat accepted after release emerges exactly 11 cycles later.
- **Parametrisation.** `PIKSEL_W=10`, `M=N=64`: `cdf_min=0`, `cdf=2048` → 512 (511.5 rounds up) with latency 13. `cdf=4096` → 1023.

Source files
------------

// File: rtl/histogram_haritalama.sv
`default_nettype none
// ============================================================================
// histogram_haritalama : pipelined histogram-equalisation mapper (CDF -> level)
// Revision 1.0 - initial release
// ============================================================================
module histogram_haritalama #(
    parameter  int M        = 320,
    parameter  int N        = 240,
    parameter  int PIKSEL_W = 8,
    parameter  int KANAL_W  = 2,
    localparam int CDF_W    = $clog2(M*N+1)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                etkin_i,
    input  logic                stal_i,
    input  logic                mod_i,
    input  logic [PIKSEL_W-1:0] piksel_i,
    input  logic [KANAL_W-1:0]  kanal_i,
    input  logic [CDF_W-1:0]    cdf_min_i,
    input  logic [CDF_W-1:0]    cdf_i,
    output logic [PIKSEL_W-1:0] sonuc_o,
    output logic [KANAL_W-1:0]  kanal_o,
    output logic                hazir_o,
    output logic                mesgul_o
);

    localparam int                DW   = CDF_W + PIKSEL_W + 2;
    localparam int                MN   = M * N;
    localparam logic [CDF_W:0]    MN_W = (CDF_W+1)'(MN);
    localparam logic [PIKSEL_W-1:0] L_W = '1;

    typedef enum logic [2:0] {
        SINIF_NORM   = 3'd0,
        SINIF_ZERO   = 3'd1,
        SINIF_IDENT  = 3'd2,
        SINIF_SAT    = 3'd3,
        SINIF_BYPASS = 3'd4
    } sinif_t;

    // S0 registers
    logic                s0_gecerli_q;
    logic [CDF_W:0]      s0_num_q, s0_num_d;
    logic [CDF_W:0]      s0_den_q, s0_den_d;
    logic [KANAL_W-1:0]  s0_kanal_q;
    logic [PIKSEL_W-1:0] s0_piksel_q;
    sinif_t              s0_sinif_q, s0_sinif_d;

    // Index 0 is S1; index k+1 holds the result of divide step k.
    logic                p_gecerli_q [0:PIKSEL_W];
    logic [KANAL_W-1:0]  p_kanal_q   [0:PIKSEL_W];
    logic [PIKSEL_W-1:0] p_piksel_q  [0:PIKSEL_W];
    sinif_t              p_sinif_q   [0:PIKSEL_W];
    logic [DW-1:0]       p_rem_q     [0:PIKSEL_W];
    logic [DW-1:0]       p_rem_d     [0:PIKSEL_W];
    logic [DW-1:0]       p_dvs_q     [0:PIKSEL_W];
    logic [DW-1:0]       p_dvs_d     [0:PIKSEL_W];
    logic [PIKSEL_W-1:0] p_quot_q    [0:PIKSEL_W];
    logic [PIKSEL_W-1:0] p_quot_d    [0:PIKSEL_W];

    logic [PIKSEL_W-1:0] sonuc_q, sonuc_d;
    logic [KANAL_W-1:0]  kanal_q;
    logic                hazir_q;
    logic                mesgul;

    always_comb begin
        s0_num_d = {1'b0, cdf_i} - {1'b0, cdf_min_i};
        s0_den_d = MN_W - {1'b0, cdf_min_i};
        if (mod_i)
            s0_sinif_d = SINIF_BYPASS;
        else if (s0_num_d[CDF_W])
            s0_sinif_d = SINIF_ZERO;
        else if (s0_den_d == '0)
            s0_sinif_d = SINIF_IDENT;
        else if ({1'b0, cdf_i} > MN_W)
            s0_sinif_d = SINIF_SAT;
        else
            s0_sinif_d = SINIF_NORM;
    end

    always_comb begin
        logic [DW-1:0] n_ext;
        n_ext       = DW'(s0_num_q);
        // 2*num*L + den, with num*L formed as (num << PIKSEL_W) - num
        p_rem_d[0]  = (n_ext << (PIKSEL_W + 1)) - (n_ext << 1) + DW'(s0_den_q);
        p_dvs_d[0]  = DW'({s0_den_q, 1'b0});
        p_quot_d[0] = '0;
        for (int k = 0; k < PIKSEL_W; k++) begin
            logic [DW-1:0] kaydir;
            logic          ge;
            kaydir        = p_dvs_q[k] << (PIKSEL_W - 1 - k);
            ge            = (p_rem_q[k] >= kaydir);
            p_rem_d[k+1]  = ge ? (p_rem_q[k] - kaydir) : p_rem_q[k];
            p_dvs_d[k+1]  = p_dvs_q[k];
            p_quot_d[k+1] = (p_quot_q[k] << 1) | PIKSEL_W'(ge);
        end
    end

    always_comb begin
        sonuc_d = '0;
        case (p_sinif_q[PIKSEL_W])
            SINIF_BYPASS: sonuc_d = p_piksel_q[PIKSEL_W];
            SINIF_ZERO:   sonuc_d = '0;
            SINIF_IDENT:  sonuc_d = p_piksel_q[PIKSEL_W];
            SINIF_SAT:    sonuc_d = L_W;
            default:      sonuc_d = p_quot_q[PIKSEL_W];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            s0_gecerli_q <= 1'b0;
            s0_num_q     <= '0;
            s0_den_q     <= '0;
            s0_kanal_q   <= '0;
            s0_piksel_q  <= '0;
            s0_sinif_q   <= SINIF_NORM;
            for (int k = 0; k <= PIKSEL_W; k++) begin
                p_gecerli_q[k] <= 1'b0;
                p_kanal_q[k]   <= '0;
                p_piksel_q[k]  <= '0;
                p_sinif_q[k]   <= SINIF_NORM;
                p_rem_q[k]     <= '0;
                p_dvs_q[k]     <= '0;
                p_quot_q[k]    <= '0;
            end
            sonuc_q <= '0;
            kanal_q <= '0;
            hazir_q <= 1'b0;
        end else if (!stal_i) begin
            s0_gecerli_q <= etkin_i;
            s0_num_q     <= s0_num_d;
            s0_den_q     <= s0_den_d;
            s0_kanal_q   <= kanal_i;
            s0_piksel_q  <= piksel_i;
            s0_sinif_q   <= s0_sinif_d;
            p_gecerli_q[0] <= s0_gecerli_q;
            p_kanal_q[0]   <= s0_kanal_q;
            p_piksel_q[0]  <= s0_piksel_q;
            p_sinif_q[0]   <= s0_sinif_q;
            for (int k = 0; k < PIKSEL_W; k++) begin
                p_gecerli_q[k+1] <= p_gecerli_q[k];
                p_kanal_q[k+1]   <= p_kanal_q[k];
                p_piksel_q[k+1]  <= p_piksel_q[k];
                p_sinif_q[k+1]   <= p_sinif_q[k];
            end
            for (int k = 0; k <= PIKSEL_W; k++) begin
                p_rem_q[k]  <= p_rem_d[k];
                p_dvs_q[k]  <= p_dvs_d[k];
                p_quot_q[k] <= p_quot_d[k];
            end
            sonuc_q <= sonuc_d;
            kanal_q <= p_kanal_q[PIKSEL_W];
            hazir_q <= p_gecerli_q[PIKSEL_W];
        end
    end

    always_comb begin
        mesgul = s0_gecerli_q | hazir_q;
        for (int k = 0; k <= PIKSEL_W; k++)
            mesgul = mesgul | p_gecerli_q[k];
    end

    assign sonuc_o  = sonuc_q;
    assign kanal_o  = kanal_q;
    assign hazir_o  = hazir_q;
    assign mesgul_o = mesgul;

endmodule
`default_nettype wire

// File: tb/tb_histogram_haritalama.sv
`default_nettype none
// ============================================================================
// tb_histogram_haritalama : scoreboard bench for the equalisation mapper
// Revision 1.0 - initial release
// ============================================================================
module tb_histogram_haritalama;

    localparam int LAT_A = 11;
    localparam int MN_A  = 76800;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        a_etkin = 1'b0, a_stal = 1'b0, a_mod = 1'b0;
    logic [7:0]  a_piksel = '0;
    logic [1:0]  a_kanal = '0;
    logic [16:0] a_cdf_min = '0, a_cdf = '0;
    logic [7:0]  a_sonuc;
    logic [1:0]  a_kanal_o;
    logic        a_hazir, a_mesgul;

    logic        b_etkin = 1'b0, b_stal = 1'b0, b_mod = 1'b0;
    logic [9:0]  b_piksel = '0;
    logic [1:0]  b_kanal = '0;
    logic [12:0] b_cdf_min = '0, b_cdf = '0;
    logic [9:0]  b_sonuc;
    logic [1:0]  b_kanal_o;
    logic        b_hazir, b_mesgul;

    histogram_haritalama u_dut_a (
        .clk_i(clk), .rstn_i(rstn), .etkin_i(a_etkin), .stal_i(a_stal), .mod_i(a_mod),
        .piksel_i(a_piksel), .kanal_i(a_kanal), .cdf_min_i(a_cdf_min), .cdf_i(a_cdf),
        .sonuc_o(a_sonuc), .kanal_o(a_kanal_o), .hazir_o(a_hazir), .mesgul_o(a_mesgul)
    );

    histogram_haritalama #(.M(64), .N(64), .PIKSEL_W(10), .KANAL_W(2)) u_dut_b (
        .clk_i(clk), .rstn_i(rstn), .etkin_i(b_etkin), .stal_i(b_stal), .mod_i(b_mod),
        .piksel_i(b_piksel), .kanal_i(b_kanal), .cdf_min_i(b_cdf_min), .cdf_i(b_cdf),
        .sonuc_o(b_sonuc), .kanal_o(b_kanal_o), .hazir_o(b_hazir), .mesgul_o(b_mesgul)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s;
        logic [1:0] k;
        int         key;
    } ent_t;

    ent_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_stal = 0;
    logic last_stal = 1'b0;
    logic [7:0] prev_s;
    logic [1:0] prev_k;
    logic       prev_h;

    function automatic logic [7:0] model_a(input logic mod, input logic [7:0] pk,
                                           input int cmin, input int c);
        longint num, den;
        if (mod)          return pk;
        if (c < cmin)     return 8'd0;
        if (cmin == MN_A) return pk;
        if (c > MN_A)     return 8'd255;
        num = c - cmin;
        den = MN_A - cmin;
        return 8'((2 * num * 255 + den) / (2 * den));
    endfunction

    // Scoreboard push: a beat is accepted on this edge when etkin && !stal.
    always @(posedge clk) begin
        if (!rstn) begin
            sb.delete();
        end else begin
            if (a_etkin && !a_stal) begin
                ent_t e;
                e.s   = model_a(a_mod, a_piksel, int'(a_cdf_min), int'(a_cdf));
                e.k   = a_kanal;
                e.key = cyc + 1 - n_stal + LAT_A - 1;
                sb.push_back(e);
            end
            if (a_stal) n_stal++;
        end
        last_stal = rstn && a_stal;
        cyc++;
    end

    // Scoreboard pop and hold check, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (last_stal) begin
                n_chk++;
                if (a_sonuc !== prev_s || a_kanal_o !== prev_k || a_hazir !== prev_h) begin
                    n_fail++;
                    $display("FAIL stall_hold: got s=%0d k=%0d h=%0b, required s=%0d k=%0d h=%0b",
                             a_sonuc, a_kanal_o, a_hazir, prev_s, prev_k, prev_h);
                end
            end
            if (a_hazir && !a_stal) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got hazir=1 s=%0d, required no beat", a_sonuc);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    if (a_sonuc !== e.s || a_kanal_o !== e.k || (cyc - n_stal) != e.key) begin
                        n_fail++;
                        $display("FAIL beat: got s=%0d k=%0d t=%0d, required s=%0d k=%0d t=%0d",
                                 a_sonuc, a_kanal_o, cyc - n_stal, e.s, e.k, e.key);
                    end
                end
            end
        end
        prev_s = a_sonuc;
        prev_k = a_kanal_o;
        prev_h = a_hazir;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic mod, input logic [7:0] pk, input logic [1:0] kn,
                           input int cmin, input int c);
        a_etkin   = 1'b1;
        a_mod     = mod;
        a_piksel  = pk;
        a_kanal   = kn;
        a_cdf_min = 17'(cmin);
        a_cdf     = 17'(c);
        tick();
        a_etkin   = 1'b0;
    endtask

    task automatic drain(output logic ok);
        int n;
        n = 0;
        while ((sb.size() != 0 || a_mesgul) && n < 80) begin
            tick();
            n++;
        end
        ok = (sb.size() == 0) && !a_mesgul;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        n_chk++;
        if (a_sonuc !== 8'd0 || a_kanal_o !== 2'd0 || a_hazir !== 1'b0 || a_mesgul !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: got s=%0d k=%0d h=%0b m=%0b, required all 0",
                     a_sonuc, a_kanal_o, a_hazir, a_mesgul);
        end
        n_chk++;
        if (b_sonuc !== 10'd0 || b_kanal_o !== 2'd0 || b_hazir !== 1'b0 || b_mesgul !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: got s=%0d k=%0d h=%0b m=%0b, required all 0",
                     b_sonuc, b_kanal_o, b_hazir, b_mesgul);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_full_range();
        int   lat;
        logic ok;
        drive_a(1'b0, 8'h11, 2'd1, 0, 76800);
        lat = 0;
        while (!a_hazir && lat < 40) begin
            tick();
            lat++;
        end
        n_chk++;
        if (lat != LAT_A - 1 || a_sonuc !== 8'd255) begin
            n_fail++;
            $display("FAIL full_range_lat: got edges=%0d s=%0d, required edges=%0d s=255",
                     lat, a_sonuc, LAT_A - 1);
        end
        drive_a(1'b0, 8'h22, 2'd2, 0, 38400);
        drive_a(1'b0, 8'h33, 2'd3, 0, 0);
        drain(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL full_range_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_order_tags();
        int   cdfs[4] = '{50, 100, 76800, 38450};
        logic ok;
        for (int i = 0; i < 4; i++)
            drive_a(1'b0, 8'(i), 2'(i), 100, cdfs[i]);
        repeat (6) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (a_hazir !== (i < 4)) begin
                n_fail++;
                $display("FAIL order_hazir[%0d]: got %0b, required %0b", i, a_hazir, i < 4);
            end
        end
        drain(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL order_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_classes();
        logic ok;
        drive_a(1'b0, 8'h3C, 2'd1, 76800, 76800);
        drive_a(1'b1, 8'h5A, 2'd2, 1234, int'($urandom_range(0, 131071)));
        drive_a(1'b0, 8'h77, 2'd3, 0, 76801);
        drive_a(1'b0, 8'h01, 2'd0, 5000, 4999);
        drain(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL classes_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_stall();
        logic ok;
        int   cmin, c;
        for (int i = 0; i < 20; i++) begin
            cmin = int'($urandom_range(0, 76000));
            c    = int'($urandom_range(0, 78000));
            a_etkin   = 1'b1;
            a_mod     = ($urandom_range(0, 7) == 0);
            a_piksel  = 8'($urandom_range(0, 255));
            a_kanal   = 2'(i);
            a_cdf_min = 17'(cmin);
            a_cdf     = 17'(c);
            if (i == 5 || i == 10 || i == 15) begin
                a_stal = 1'b1;
                repeat ((i == 5) ? 1 : (i == 10) ? 3 : 7) tick();
                a_stal = 1'b0;
            end
            tick();
        end
        a_etkin = 1'b0;
        repeat (4) tick();
        a_stal = 1'b1;
        repeat (2) tick();
        a_stal = 1'b0;
        drain(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int   seen, lat;
        logic ok;
        for (int i = 0; i < 5; i++)
            drive_a(1'b0, 8'(i), 2'(i), 0, 1000 * (i + 1));
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n_chk++;
        if (a_hazir !== 1'b0 || a_mesgul !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_flush: got h=%0b m=%0b, required 0 0", a_hazir, a_mesgul);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (a_hazir) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_ghost: got %0d beats, required 0", seen);
        end
        drive_a(1'b0, 8'h44, 2'd2, 0, 38400);
        lat = 0;
        while (!a_hazir && lat < 40) begin
            tick();
            lat++;
        end
        n_chk++;
        if (lat != LAT_A - 1 || a_sonuc !== 8'd128) begin
            n_fail++;
            $display("FAIL reset_mid_lat: got edges=%0d s=%0d, required edges=%0d s=128",
                     lat, a_sonuc, LAT_A - 1);
        end
        drain(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_mid_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_param();
        int cdfs[2] = '{2048, 4096};
        int exps[2] = '{512, 1023};
        int lat;
        for (int i = 0; i < 2; i++) begin
            b_etkin   = 1'b1;
            b_cdf_min = '0;
            b_cdf     = 13'(cdfs[i]);
            b_kanal   = 2'(i + 1);
            tick();
            b_etkin = 1'b0;
            lat = 0;
            while (!b_hazir && lat < 40) begin
                tick();
                lat++;
            end
            n_chk++;
            if (lat != 12 || b_sonuc !== 10'(exps[i]) || b_kanal_o !== 2'(i + 1)) begin
                n_fail++;
                $display("FAIL param[%0d]: got edges=%0d s=%0d k=%0d, required edges=12 s=%0d k=%0d",
                         i, lat, b_sonuc, b_kanal_o, exps[i], i + 1);
            end
            repeat (3) tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_range();
        test_order_tags();
        test_classes();
        test_stall();
        test_reset_mid();
        test_param();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
